// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
// Memory-side bus of the multicycle CPU's access unit.
//   mem_cmd    2   00 none, 01 read, 10 write
//   mem_addr   AW  access address
//   mem_wdata  DW  store data
//   mem_rdata  DW  read data returned by the memory
//   mem_ready  1   memory completes the current access this cycle
// Modports: master = access unit, slave = RAM / IO decode.
// -----------------------------------------------------------------------------
interface mem_access_unit_if #(
    parameter int AW = 9,
    parameter int DW = 16
);
    logic [1:0]    mem_cmd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport master (
        output mem_cmd, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_cmd, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Owns the PC, data-address (da) and store-data (sd) registers, issues memory
// commands and waits on a variable-latency memory, aborting after MAX_WAIT
// wait cycles.
//   clk, reset        clock, asynchronous active-low reset
//   fetch_req         fetch from PC (IDLE only)
//   ldst_req/_write   data access, 1 = store (IDLE only); addr_in/wr_data latched
//   pc_load/_mode/_val  PC update, 0 = relative, 1 = absolute (IDLE only)
//   mem               memory bus (master side)
//   instr, ldata      last fetched instruction / loaded data
//   pc                current PC
//   busy, done, err   not idle / one-cycle completion pulse / sticky timeout
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int            AW       = 9,
    parameter int            DW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int            MAX_WAIT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_req,
    input  logic                 ldst_req,
    input  logic                 ldst_write,
    input  logic [AW-1:0]        addr_in,
    input  logic [DW-1:0]        wr_data,
    input  logic                 pc_load,
    input  logic                 pc_mode,
    input  logic [DW-1:0]        pc_val,
    mem_access_unit_if.master    mem,
    output logic [DW-1:0]        instr,
    output logic [DW-1:0]        ldata,
    output logic [AW-1:0]        pc,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;

    state_t        state, state_nx;
    logic [WW-1:0] wcnt;
    logic [AW-1:0] da;
    logic [DW-1:0] sd;
    logic [AW-1:0] pc_idle;
    logic          timed_out;
    logic [1:0]    cmd;
    logic [AW-1:0] addr;

    // Only the low AW bits of pc_val take part in either PC mode.
    logic unused_pc_val_hi;
    assign unused_pc_val_hi = ^pc_val[DW-1:AW];

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_nx  = state;
        cmd       = 2'b00;
        addr      = '0;
        timed_out = !mem.mem_ready && (wcnt == WW'(MAX_WAIT));
        // PC after a possible pc_load; a fetch accepted on the same edge
        // therefore reads from the updated PC.
        pc_idle   = pc;
        if (pc_load) pc_idle = pc_mode ? pc_val[AW-1:0] : pc + pc_val[AW-1:0];

        unique case (state)
            IDLE: begin
                // ldst wins over fetch; a losing fetch is simply dropped.
                if (ldst_req)       state_nx = ldst_write ? STORE : LOAD;
                else if (fetch_req) state_nx = FETCH;
            end
            FETCH: begin
                cmd  = 2'b01;
                addr = pc;
                if (mem.mem_ready || timed_out) state_nx = IDLE;
            end
            LOAD: begin
                cmd  = 2'b01;
                addr = da;
                if (mem.mem_ready || timed_out) state_nx = IDLE;
            end
            STORE: begin
                cmd  = 2'b10;
                addr = da;
                if (mem.mem_ready || timed_out) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Bus outputs decode from the state register, so an asynchronous reset
    // drops mem_cmd to 00 immediately.
    assign mem.mem_cmd   = cmd;
    assign mem.mem_addr  = addr;
    assign mem.mem_wdata = sd;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc    <= RESET_PC;
            instr <= '0;
            ldata <= '0;
            da    <= '0;
            sd    <= '0;
            wcnt  <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                pc   <= pc_idle;
                wcnt <= '0;   // every access state is entered from IDLE
                if (ldst_req) begin
                    da <= addr_in;
                    sd <= wr_data;
                end
            end else if (mem.mem_ready) begin
                done <= 1'b1;
                if (state == FETCH) begin
                    instr <= mem.mem_rdata;
                    pc    <= pc + AW'(1);
                end
                if (state == LOAD) ldata <= mem.mem_rdata;
            end else if (timed_out) begin
                // Abort: flag and report, architectural state untouched.
                done <= 1'b1;
                err  <= 1'b1;
            end else begin
                wcnt <= wcnt + WW'(1);
            end
        end
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised program-counter / data-address / memory-handshake unit for the multicycle CPU. It owns the PC and the data-address and store-data registers, drives the memory command and address, and waits on a variable-latency memory. It returns fetched instructions and loaded data to the control FSM, supports relative and absolute PC loads, and aborts hung accesses with a timeout. It sits between the control FSM/datapath and the RAM/IO decode, replacing the fixed-width PC register, PC mux and zero-wait address mux.

## Interface
- AW, 9: address width (PC, data address, mem_addr)
- DW, 16: data/instruction width
- RESET_PC, 0: PC value after reset (AW bits)
- MAX_WAIT, 15: cycles an access may wait for mem_ready before timeout (>=1)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- fetch_req  in  1  start instruction fetch from PC (sampled in IDLE only)
- ldst_req  in  1  start data access (sampled in IDLE only)
- ldst_write  in  1  with ldst_req: 1 = store, 0 = load
- addr_in  in  AW  data address, latched into DA on ldst accept
- wr_data  in  DW  store data, latched on ldst accept
- pc_load  in  1  update PC (accepted in IDLE only)
- pc_mode  in  1  0 = relative (PC + pc_val), 1 = absolute (PC = pc_val[AW-1:0])
- pc_val  in  DW  signed offset or absolute target
- mem_cmd  out  2  00 none, 01 read, 10 write
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  store data to memory
- mem_rdata  in  DW  read data from memory
- mem_ready  in  1  memory completes current access this cycle
- instr  out  DW  last fetched instruction (registered)
- ldata  out  DW  last loaded data (registered)
- pc  out  AW  current PC
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse: access completed or aborted
- err  out  1  sticky timeout flag; cleared by reset only

## Operation
- States: IDLE, FETCH, LOAD, STORE. Reset -> IDLE; PC=RESET_PC; instr, ldata, DA, store-data register = 0; done=err=busy=0; mem_cmd=00; mem_addr=0.
- IDLE priority on one edge: pc_load applies first; then ldst_req wins over fetch_req. A losing fetch_req is dropped, not queued.
- pc_load relative: PC <= PC + pc_val[AW-1:0], two's complement, modulo 2^AW. Absolute: PC <= pc_val[AW-1:0].
- A fetch accepted on the same edge as pc_load uses the new PC.
- pc_load, fetch_req and ldst_req outside IDLE are ignored.
- FETCH: mem_cmd=01, mem_addr=PC. On mem_ready: instr <= mem_rdata, PC <= PC+1 mod 2^AW (2^AW-1 wraps to 0), -> IDLE.
- LOAD: mem_cmd=01, mem_addr=DA. On mem_ready: ldata <= mem_rdata, -> IDLE.
- STORE: mem_cmd=10, mem_addr=DA, mem_wdata=store-data register. On mem_ready: -> IDLE.
- In IDLE: mem_cmd=00, mem_addr=0, mem_wdata=store-data register.
- Wait counter: cleared on entry to each access state, incremented each cycle without mem_ready. When mem_ready is still 0 at the end of wait cycle MAX_WAIT, the access aborts and goes to IDLE. On abort: err <= 1, done pulses, instr/ldata/PC are unchanged.
- mem_ready while in IDLE is ignored.

## Timing
- Request accepted at edge E0; access state and mem_cmd valid from E0 until the completion edge.
- mem_ready=1 in the first access cycle: completion at edge E1, done=1 during cycle E1–E2. Minimum request-to-done is 1 cycle; n wait cycles add n.
- done is high exactly one cycle; busy falls on the same edge done rises. A new request may be accepted on the edge that ends the done cycle.
- instr/ldata/PC update on the completion edge and are valid while done=1.
- Timeout: abort edge is MAX_WAIT+1 edges after entry; done and err rise together.
- Asynchronous reset mid-access: all outputs go to reset values immediately; mem_cmd=00 without waiting for a clock edge; no partial update is retained.

## Test plan
- Reset then fetch: RESET_PC=0, mem returns 16'hD105 with 0 waits -> mem_cmd=01 and mem_addr=0 for 1 cycle; instr=D105, pc=1, done one cycle.
- Wrap and relative branch: PC=9'h1FF, fetch -> pc=0. Then pc_load rel with pc_val=16'hFFFE -> pc=9'h1FE. Then abs with pc_val=16'h0123 -> pc=9'h123.
- Store/load with waits: store addr 9'h140, data 16'hABCD, ready after 3 waits -> mem_cmd=10 for 4 cycles. Load same address, mem returns ABCD -> ldata=ABCD, pc unchanged.
- Simultaneous: pc_load abs 9'h010 + ldst_req load + fetch_req in one IDLE cycle -> pc=010, LOAD executes, no fetch follows.
- Timeout: MAX_WAIT=15, fetch with mem_ready held 0 -> abort 16 edges after entry; err=1, done pulse, pc and instr unchanged. A following good fetch completes with err still 1.
- Reset mid-LOAD after 2 wait cycles -> mem_cmd=00, busy=0, ldata=0, pc=RESET_PC immediately; no done pulse after release.
